// File: rtl/hsiao_ecc_codec_if.sv
// Port bundle for hsiao_ecc_codec: encoder and decoder request/response signals.
// The master modport drives the codec inputs; the codec itself uses the slave modport.
interface hsiao_ecc_codec_if #(
  parameter int DataWidth = 32
);
  // Smallest r with 2^(r-1) >= DataWidth + r
  function automatic int calc_prot(input int dw);
    int r;
    r = 1;
    while ((1 << (r - 1)) < (dw + r)) r++;
    return r;
  endfunction

  localparam int ProtWidth = calc_prot(DataWidth);
  localparam int CodeWidth = DataWidth + ProtWidth;

  logic                 enc_valid_i;
  logic [DataWidth-1:0] enc_data_i;
  logic                 enc_valid_o;
  logic [CodeWidth-1:0] enc_code_o;
  logic                 dec_valid_i;
  logic [CodeWidth-1:0] dec_code_i;
  logic                 dec_valid_o;
  logic [DataWidth-1:0] dec_data_o;
  logic [ProtWidth-1:0] dec_syndrome_o;
  logic [1:0]           dec_err_o;
  logic [15:0]          cnt_corr_o;
  logic [15:0]          cnt_uncorr_o;

  modport master (
    output enc_valid_i, enc_data_i, dec_valid_i, dec_code_i,
    input  enc_valid_o, enc_code_o, dec_valid_o, dec_data_o,
           dec_syndrome_o, dec_err_o, cnt_corr_o, cnt_uncorr_o
  );

  modport slave (
    input  enc_valid_i, enc_data_i, dec_valid_i, dec_code_i,
    output enc_valid_o, enc_code_o, dec_valid_o, dec_data_o,
           dec_syndrome_o, dec_err_o, cnt_corr_o, cnt_uncorr_o
  );
endinterface

// File: rtl/hsiao_ecc_codec.sv
// Registered Hsiao SECDED encoder + decoder, 1-cycle latency on each independent path.
// Optional error counters are built only when HSIAO_ECC_ERR_CNT_EN is defined.
module hsiao_ecc_codec #(
  parameter int DataWidth = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  hsiao_ecc_codec_if.slave  bus
);
  function automatic int calc_prot(input int dw);
    int r;
    r = 1;
    while ((1 << (r - 1)) < (dw + r)) r++;
    return r;
  endfunction

  localparam int ProtWidth = calc_prot(DataWidth);
  localparam int CodeWidth = DataWidth + ProtWidth;

  // Data columns: odd-weight (>=3) vectors, ordered by weight then value
  function automatic logic [DataWidth-1:0][ProtWidth-1:0] gen_cols();
    int idx;
    int wt;
    gen_cols = '0;
    idx = 0;
    for (int w = 3; w <= ProtWidth; w += 2) begin
      for (int v = 0; v < (1 << ProtWidth); v++) begin
        wt = 0;
        for (int b = 0; b < ProtWidth; b++) wt += (v >> b) & 1;
        if (wt == w && idx < DataWidth) begin
          gen_cols[idx] = v[ProtWidth-1:0];
          idx++;
        end
      end
    end
  endfunction

  localparam logic [DataWidth-1:0][ProtWidth-1:0] H_COLS = gen_cols();

  function automatic logic [ProtWidth-1:0] parity_of(input logic [DataWidth-1:0] d);
    parity_of = '0;
    for (int i = 0; i < DataWidth; i++)
      if (d[i]) parity_of = parity_of ^ H_COLS[i];
  endfunction

  logic [ProtWidth-1:0] w_enc_par;
  logic [DataWidth-1:0] w_rx_data;
  logic [ProtWidth-1:0] w_rx_par;
  logic [ProtWidth-1:0] w_syn;
  logic [DataWidth-1:0] w_hit;
  logic                 w_syn_one;
  logic [1:0]           w_err;

  assign w_enc_par = parity_of(bus.enc_data_i);
  assign w_rx_data = bus.dec_code_i[DataWidth-1:0];
  assign w_rx_par  = bus.dec_code_i[CodeWidth-1:DataWidth];
  assign w_syn     = w_rx_par ^ parity_of(w_rx_data);

  for (genvar gi = 0; gi < DataWidth; gi++) begin : g_hit
    assign w_hit[gi] = (w_syn == H_COLS[gi]);
  end

  // Weight-1 syndrome means the flipped bit was a check bit
  assign w_syn_one = (w_syn != '0) && ((w_syn & (w_syn - ProtWidth'(1))) == '0);

  always_comb begin
    w_err = 2'b00;
    if (w_syn != '0) begin
      if ((|w_hit) || w_syn_one) w_err = 2'b01;
      else                       w_err = 2'b10;
    end
  end

  logic                 r_enc_valid;
  logic [CodeWidth-1:0] r_enc_code;
  logic                 r_dec_valid;
  logic [DataWidth-1:0] r_dec_data;
  logic [ProtWidth-1:0] r_dec_syn;
  logic [1:0]           r_dec_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_enc_valid <= 1'b0;
      r_enc_code  <= '0;
      r_dec_valid <= 1'b0;
      r_dec_data  <= '0;
      r_dec_syn   <= '0;
      r_dec_err   <= 2'b00;
    end else begin
      r_enc_valid <= bus.enc_valid_i;
      r_dec_valid <= bus.dec_valid_i;
      if (bus.enc_valid_i) r_enc_code <= {w_enc_par, bus.enc_data_i};
      if (bus.dec_valid_i) begin
        r_dec_data <= w_rx_data ^ w_hit;
        r_dec_syn  <= w_syn;
        r_dec_err  <= w_err;
      end
    end
  end

  assign bus.enc_valid_o    = r_enc_valid;
  assign bus.enc_code_o     = r_enc_code;
  assign bus.dec_valid_o    = r_dec_valid;
  assign bus.dec_data_o     = r_dec_data;
  assign bus.dec_syndrome_o = r_dec_syn;
  assign bus.dec_err_o      = r_dec_err;

`ifdef HSIAO_ECC_ERR_CNT_EN
  logic [15:0] r_cnt_corr;
  logic [15:0] r_cnt_uncorr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
    end else if (bus.dec_valid_i) begin
      if (w_err[0] && r_cnt_corr != 16'hFFFF)   r_cnt_corr   <= r_cnt_corr + 16'd1;
      if (w_err[1] && r_cnt_uncorr != 16'hFFFF) r_cnt_uncorr <= r_cnt_uncorr + 16'd1;
    end
  end

  assign bus.cnt_corr_o   = r_cnt_corr;
  assign bus.cnt_uncorr_o = r_cnt_uncorr;
`else
  assign bus.cnt_corr_o   = 16'd0;
  assign bus.cnt_uncorr_o = 16'd0;
`endif
endmodule

// File: tb/tb_hsiao_ecc_codec.sv
// Self-checking bench for hsiao_ecc_codec (DataWidth = 32): vector table, random
// single/double flip sweep, reset-under-load and, with the counter macro, saturation.
module tb_hsiao_ecc_codec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hsiao_ecc_codec_if #(.DataWidth(32)) bus ();
  hsiao_ecc_codec #(.DataWidth(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    bit          ev;
    logic [31:0] ed;
    logic [38:0] ee;
    bit          dv;
    logic [38:0] dc;
    logic [31:0] xd;
    logic [6:0]  xs;
    logic [1:0]  xe;
  } vec_t;

  typedef struct {
    bit          ev;
    logic [38:0] code;
    bit          dv;
    logic [31:0] data;
    logic [6:0]  syn;
    logic [1:0]  err;
    logic [15:0] ccorr;
    logic [15:0] cunc;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[10];
  logic [6:0]  cols[32];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [38:0] last_code;
  logic [31:0] last_data;
  logic [6:0]  last_syn;
  logic [1:0]  last_err;
  logic [15:0] exp_corr;
  logic [15:0] exp_unc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [38:0] model_enc(input logic [31:0] d);
    logic [6:0] p;
    p = 7'h00;
    for (int i = 0; i < 32; i++) if (d[i]) p = p ^ cols[i];
    return {p, d};
  endfunction

  function automatic logic [6:0] bit_col(input int b);
    logic [6:0] one;
    one = 7'h01;
    return (b < 32) ? cols[b] : (one << (b - 32));
  endfunction

  task automatic check_out();
    exp_t r;
    if (sb.size() == 0) return;
    r = sb.pop_front();
    chk("enc_valid", 64'(bus.enc_valid_o), 64'(r.ev));
    chk("enc_code", 64'(bus.enc_code_o), 64'(r.code));
    chk("dec_valid", 64'(bus.dec_valid_o), 64'(r.dv));
    chk("dec_data", 64'(bus.dec_data_o), 64'(r.data));
    chk("dec_syn", 64'(bus.dec_syndrome_o), 64'(r.syn));
    chk("dec_err", 64'(bus.dec_err_o), 64'(r.err));
`ifdef HSIAO_ECC_ERR_CNT_EN
    chk("cnt_corr", 64'(bus.cnt_corr_o), 64'(r.ccorr));
    chk("cnt_uncorr", 64'(bus.cnt_uncorr_o), 64'(r.cunc));
`else
    chk("cnt_corr_tied", 64'(bus.cnt_corr_o), 64'd0);
    chk("cnt_uncorr_tied", 64'(bus.cnt_uncorr_o), 64'd0);
`endif
  endtask

  task automatic step(input vec_t v);
    exp_t r;
    @(negedge clk);
    check_out();
    bus.enc_valid_i = v.ev;
    bus.enc_data_i  = v.ed;
    bus.dec_valid_i = v.dv;
    bus.dec_code_i  = v.dc;
    if (v.ev) last_code = v.ee;
    if (v.dv) begin
      last_data = v.xd;
      last_syn  = v.xs;
      last_err  = v.xe;
      if (v.xe == 2'b01 && exp_corr != 16'hFFFF) exp_corr = exp_corr + 16'd1;
      if (v.xe == 2'b10 && exp_unc != 16'hFFFF)  exp_unc  = exp_unc + 16'd1;
    end
    r = '{v.ev, last_code, v.dv, last_data, last_syn, last_err, exp_corr, exp_unc};
    sb.push_back(r);
  endtask

  task automatic do_reset();
    exp_t r;
    @(negedge clk);
    check_out();
    rst = 1'b1;
    bus.enc_valid_i = 1'b1;
    bus.enc_data_i  = $urandom;
    bus.dec_valid_i = 1'b1;
    bus.dec_code_i  = {7'h07, $urandom};
    @(negedge clk);
    chk("rst_enc_valid", 64'(bus.enc_valid_o), 64'd0);
    chk("rst_enc_code", 64'(bus.enc_code_o), 64'd0);
    chk("rst_dec_valid", 64'(bus.dec_valid_o), 64'd0);
    chk("rst_dec_data", 64'(bus.dec_data_o), 64'd0);
    chk("rst_dec_syn", 64'(bus.dec_syndrome_o), 64'd0);
    chk("rst_dec_err", 64'(bus.dec_err_o), 64'd0);
    chk("rst_cnt_corr", 64'(bus.cnt_corr_o), 64'd0);
    chk("rst_cnt_uncorr", 64'(bus.cnt_uncorr_o), 64'd0);
    rst = 1'b0;
    bus.enc_valid_i = 1'b0;
    bus.dec_valid_i = 1'b0;
    last_code = '0; last_data = '0; last_syn = '0; last_err = '0;
    exp_corr = '0; exp_unc = '0;
    sb.delete();
    r = '{1'b0, 39'd0, 1'b0, 32'd0, 7'd0, 2'd0, 16'd0, 16'd0};
    sb.push_back(r);
  endtask

  initial begin
    vec_t v;
    int   idx;
    logic [38:0] code;
    logic [31:0] d;

    // Independent column list: weight-3 7-bit values in ascending order
    idx = 0;
    for (int x = 0; x < 128; x++) begin
      if ($countones(x[6:0]) == 3 && idx < 32) begin
        cols[idx] = x[6:0];
        idx++;
      end
    end

    bus.enc_valid_i = 1'b0; bus.enc_data_i = '0;
    bus.dec_valid_i = 1'b0; bus.dec_code_i = '0;
    do_reset();

    //         ev  ed            ee                    dv  dc                  xd            xs     xe
    tbl[0] = '{1, 32'h0,        {7'h00, 32'h0},        1, {7'h00, 32'h0},     32'h0,        7'h00, 2'b00};
    tbl[1] = '{1, 32'h1,        {7'h07, 32'h1},        1, {7'h07, 32'h0},     32'h1,        7'h07, 2'b01};
    tbl[2] = '{1, 32'h3,        {7'h0C, 32'h3},        1, {7'h01, 32'h0},     32'h0,        7'h01, 2'b01};
    tbl[3] = '{0, 32'h0,        39'h0,                 1, {7'h00, 32'h3},     32'h3,        7'h0C, 2'b10};
    tbl[4] = '{1, 32'h80000000, {7'h62, 32'h80000000}, 1, {7'h62, 32'h0},     32'h80000000, 7'h62, 2'b01};
    tbl[5] = '{0, 32'h0,        39'h0,                 0, 39'h0,              32'h0,        7'h00, 2'b00};
    tbl[6] = '{1, 32'h400,      {7'h23, 32'h400},      1, {7'h70, 32'h0},     32'h0,        7'h70, 2'b10};
    tbl[7] = '{1, 32'h5,        {7'h0A, 32'h5},        1, {7'h40, 32'h0},     32'h0,        7'h40, 2'b01};
    tbl[8] = '{0, 32'h0,        39'h0,                 1, {7'h1F, 32'h0},     32'h0,        7'h1F, 2'b10};
    tbl[9] = '{1, 32'h2,        {7'h0B, 32'h2},        1, {7'h0B, 32'h0},     32'h2,        7'h0B, 2'b01};
    for (int i = 0; i < 10; i++) step(tbl[i]);

    // Back-to-back: clean, every single flip, and one double flip per word
    for (int w = 0; w < 4; w++) begin
      d    = $urandom;
      code = model_enc(d);
      for (int f = -1; f <= 39; f++) begin
        v.ev = 1'b1;
        v.ed = $urandom;
        v.ee = model_enc(v.ed);
        v.dv = 1'b1;
        if (f < 0) begin
          v.dc = code; v.xd = d; v.xs = 7'h00; v.xe = 2'b00;
        end else if (f < 39) begin
          v.dc = code ^ (39'd1 << f); v.xd = d; v.xs = bit_col(f); v.xe = 2'b01;
        end else begin
          v.dc = code ^ 39'd1 ^ (39'd1 << (w + 5));
          v.xd = v.dc[31:0]; v.xs = cols[0] ^ cols[w + 5]; v.xe = 2'b10;
        end
        step(v);
      end
    end

    // Reset while both paths are busy, then a correct first result
    do_reset();
    v = '{1, 32'h1, {7'h07, 32'h1}, 1, {7'h07, 32'h0}, 32'h1, 7'h07, 2'b01};
    step(v);
    v = '{1, 32'h3, {7'h0C, 32'h3}, 1, {7'h00, 32'h3}, 32'h3, 7'h0C, 2'b10};
    step(v);

`ifdef HSIAO_ECC_ERR_CNT_EN
    // Drive past 0xFFFF uncorrectable results; the counter must stick at 0xFFFF
    v = '{0, 32'h0, 39'h0, 1, {7'h00, 32'h3}, 32'h3, 7'h0C, 2'b10};
    for (int i = 0; i < 65536; i++) step(v);
`endif

    v = '{0, 32'h0, 39'h0, 0, 39'h0, 32'h0, 7'h00, 2'b00};
    step(v);
    @(negedge clk);
    check_out();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
